// File: rtl/axi_stream_upsizer.sv
// axi_stream_upsizer: packs RATIO consecutive narrow stream beats into one
// wide beat in front of the wide stream FIFO. Lane 0 holds the first beat in
// the LSBs; the lane accumulator restarts on every packet end.
// One registered output stage; input is stalled only while that register
// holds a word the sink has not yet taken.
// Optional build macro AXI_UPSIZER_STATS_EN adds packet and error counters
// (o_pkt_cnt, o_err_cnt); without it those ports do not exist.
module axi_stream_upsizer #(
  parameter int IN_BITS      = 64,
  parameter int RATIO        = 4,
  parameter int OUT_BITS     = IN_BITS * RATIO,
  parameter int CTL_BITS     = 8,
  parameter int IN_MOD_BITS  = $clog2(IN_BITS / 8),
  parameter int OUT_MOD_BITS = $clog2(OUT_BITS / 8)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  // narrow input stream
  input  logic [IN_BITS-1:0]      i_axi_dat,
  input  logic [CTL_BITS-1:0]     i_axi_ctl,
  input  logic [IN_MOD_BITS-1:0]  i_axi_mod,
  input  logic                    i_axi_sop,
  input  logic                    i_axi_eop,
  input  logic                    i_axi_err,
  input  logic                    i_axi_val,
  output logic                    i_axi_rdy,
  // wide output stream
  output logic [OUT_BITS-1:0]     o_axi_dat,
  output logic [CTL_BITS-1:0]     o_axi_ctl,
  output logic [OUT_MOD_BITS-1:0] o_axi_mod,
  output logic                    o_axi_sop,
  output logic                    o_axi_eop,
  output logic                    o_axi_err,
  output logic                    o_axi_val,
  input  logic                    o_axi_rdy,
`ifdef AXI_UPSIZER_STATS_EN
  output logic [31:0]             o_pkt_cnt,
  output logic [31:0]             o_err_cnt,
`endif
  output logic                    o_busy
);

  localparam int CNT_W    = $clog2(RATIO);
  localparam int IN_BYTES = IN_BITS / 8;

  // Byte count of the closing word folded into the mod encoding (0 = full).
  function automatic logic [OUT_MOD_BITS-1:0] eop_mod(
    input logic [CNT_W-1:0]       lane,
    input logic [IN_MOD_BITS-1:0] mod_in
  );
    logic [OUT_MOD_BITS:0] bytes;
    bytes = (OUT_MOD_BITS+1)'(lane) * (OUT_MOD_BITS+1)'(IN_BYTES)
          + ((mod_in == '0) ? (OUT_MOD_BITS+1)'(IN_BYTES)
                            : (OUT_MOD_BITS+1)'(mod_in));
    return bytes[OUT_MOD_BITS-1:0];
  endfunction

  // accumulation state
  logic [CNT_W-1:0]    cnt_p0;
  logic [OUT_BITS-1:0] acc_p0;
  logic [CTL_BITS-1:0] ctl_p0;
  logic                sop_p0;
  logic                err_p0;

  logic                accept;
  logic                lane0;
  logic                closing;
  logic                fault;
  logic [OUT_BITS-1:0] merged;
  logic                word_err;
  logic                word_sop;
  logic [CTL_BITS-1:0] word_ctl;

  assign i_axi_rdy = i_rst_n && (~o_axi_val || o_axi_rdy);
  assign accept    = i_axi_val && i_axi_rdy;
  assign lane0     = (cnt_p0 == '0);
  assign closing   = accept && ((cnt_p0 == CNT_W'(RATIO - 1)) || i_axi_eop);
  // A start marker in the middle of a word is packed as data but poisons the word.
  assign fault     = accept && i_axi_sop && !lane0;
  assign word_err  = err_p0 | i_axi_err | fault;
  assign word_sop  = lane0 ? i_axi_sop : sop_p0;
  assign word_ctl  = lane0 ? i_axi_ctl : ctl_p0;
  assign o_busy    = !lane0;

  // Drop the incoming beat into its lane; lanes above it are still zero.
  always_comb begin
    merged = acc_p0;
    merged[cnt_p0*IN_BITS +: IN_BITS] = i_axi_dat;
  end

  // ---- stage p0: lane accumulator ----
  // Advance the lane count and collect beats until a closing beat empties it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_p0 <= '0;
      acc_p0 <= '0;
      ctl_p0 <= '0;
      sop_p0 <= 1'b0;
      err_p0 <= 1'b0;
    end else if (accept) begin
      if (closing) begin
        cnt_p0 <= '0;
        acc_p0 <= '0;
        err_p0 <= 1'b0;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
        acc_p0 <= merged;
        err_p0 <= word_err;
        if (lane0) begin
          ctl_p0 <= i_axi_ctl;
          sop_p0 <= i_axi_sop;
        end
      end
    end
  end

  // ---- stage p1: output register ----
  // Load a finished word on its closing beat, otherwise drain after handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_axi_val <= 1'b0;
      o_axi_dat <= '0;
      o_axi_ctl <= '0;
      o_axi_mod <= '0;
      o_axi_sop <= 1'b0;
      o_axi_eop <= 1'b0;
      o_axi_err <= 1'b0;
    end else if (closing) begin
      o_axi_val <= 1'b1;
      o_axi_dat <= merged;
      o_axi_ctl <= word_ctl;
      o_axi_mod <= i_axi_eop ? eop_mod(cnt_p0, i_axi_mod) : '0;
      o_axi_sop <= word_sop;
      o_axi_eop <= i_axi_eop;
      o_axi_err <= word_err;
    end else if (o_axi_val && o_axi_rdy) begin
      o_axi_val <= 1'b0;
    end
  end

`ifdef AXI_UPSIZER_STATS_EN
  // Count delivered packet ends and delivered errored words.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pkt_cnt <= '0;
      o_err_cnt <= '0;
    end else if (o_axi_val && o_axi_rdy) begin
      if (o_axi_eop) o_pkt_cnt <= o_pkt_cnt + 32'd1;
      if (o_axi_err) o_err_cnt <= o_err_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_upsizer.sv
// Bench for axi_stream_upsizer (IN_BITS=64, RATIO=4): scoreboard of expected
// wide words built from the driven narrow beats, compared at output handshake.
module tb_axi_stream_upsizer;

  localparam int IN  = 64;
  localparam int R   = 4;
  localparam int OUT = IN * R;
  localparam int IMW = 3;
  localparam int OMW = 5;

  typedef struct packed {
    logic [OUT-1:0] dat;
    logic [7:0]     ctl;
    logic [OMW-1:0] mod;
    logic           sop;
    logic           eop;
    logic           err;
  } word_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IN-1:0]   i_dat = '0;
  logic [7:0]      i_ctl = '0;
  logic [IMW-1:0]  i_mod = '0;
  logic            i_sop = 1'b0, i_eop = 1'b0, i_err = 1'b0, i_val = 1'b0;
  logic            i_rdy;
  logic [OUT-1:0]  o_dat;
  logic [7:0]      o_ctl;
  logic [OMW-1:0]  o_mod;
  logic            o_sop, o_eop, o_err, o_val;
  logic            o_rdy = 1'b1;
  logic            busy;
`ifdef AXI_UPSIZER_STATS_EN
  logic [31:0]     pkt_cnt, err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  word_t          exp_q[$];
  int             m_cnt = 0;
  logic [OUT-1:0] m_acc = '0;
  logic           m_sop = 1'b0, m_err = 1'b0;
  logic [7:0]     m_ctl = '0;
  int             exp_pkts = 0, exp_errs = 0;

  always #5 clk = ~clk;

  axi_stream_upsizer #(.IN_BITS(IN), .RATIO(R), .CTL_BITS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_axi_dat(i_dat), .i_axi_ctl(i_ctl), .i_axi_mod(i_mod),
    .i_axi_sop(i_sop), .i_axi_eop(i_eop), .i_axi_err(i_err),
    .i_axi_val(i_val), .i_axi_rdy(i_rdy),
    .o_axi_dat(o_dat), .o_axi_ctl(o_ctl), .o_axi_mod(o_mod),
    .o_axi_sop(o_sop), .o_axi_eop(o_eop), .o_axi_err(o_err),
    .o_axi_val(o_val), .o_axi_rdy(o_rdy),
`ifdef AXI_UPSIZER_STATS_EN
    .o_pkt_cnt(pkt_cnt), .o_err_cnt(err_cnt),
`endif
    .o_busy(busy)
  );

  // Reference packing: one accepted beat updates the model word.
  task automatic model_accept(input logic [IN-1:0] d, input logic s, input logic e,
                              input logic [IMW-1:0] md, input logic er, input logic [7:0] c);
    word_t w;
    int    bytes;
    if (m_cnt == 0) begin
      m_sop = s; m_ctl = c; m_acc = '0; m_err = 1'b0;
    end else if (s) begin
      m_err = 1'b1;
    end
    m_err = m_err | er;
    m_acc[m_cnt*IN +: IN] = d;
    if (m_cnt == R-1 || e) begin
      bytes = m_cnt * 8 + ((md == 0) ? 8 : int'(md));
      w.dat = m_acc; w.ctl = m_ctl; w.sop = m_sop; w.eop = e; w.err = m_err;
      w.mod = e ? OMW'(bytes % 32) : '0;
      exp_q.push_back(w);
      if (e) exp_pkts++;
      if (m_err) exp_errs++;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic drive_beat(input logic [IN-1:0] d, input logic s, input logic e,
                            input logic [IMW-1:0] md, input logic er, input logic [7:0] c);
    i_dat = d; i_sop = s; i_eop = e; i_mod = md; i_err = er; i_ctl = c; i_val = 1'b1;
  endtask

  // Returns at posedge+1 after the beat was taken; waits = stalled cycles.
  task automatic wait_accept(output int waits);
    waits = 0;
    forever begin
      @(negedge clk);
      if (i_rdy) break;
      waits++;
      if (waits > 100) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: i_axi_rdy=%0b after %0d cycles, required 1", i_rdy, waits);
        i_val = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    i_val = 1'b0;
  endtask

  task automatic send_beat(input logic [IN-1:0] d, input logic s, input logic e,
                           input logic [IMW-1:0] md, input logic er, input logic [7:0] c,
                           output int waits);
    drive_beat(d, s, e, md, er, c);
    wait_accept(waits);
    if (waits <= 100) model_accept(d, s, e, md, er, c);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk); t++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Pops the scoreboard on every output handshake.
  task automatic monitor();
    word_t w, got;
    forever begin
      @(negedge clk);
      if (rst_n && o_val && o_rdy) begin
        got = {o_dat, o_ctl, o_mod, o_sop, o_eop, o_err};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got dat=%h with nothing expected", o_dat);
        end else begin
          w = exp_q.pop_front();
          if (got !== w) begin
            n_fail++;
            $display("FAIL out_word: got dat=%h ctl=%h mod=%0d sop=%0b eop=%0b err=%0b", o_dat, o_ctl, o_mod, o_sop, o_eop, o_err);
            $display("  required dat=%h ctl=%h mod=%0d sop=%0b eop=%0b err=%0b", w.dat, w.ctl, w.mod, w.sop, w.eop, w.err);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o_val, busy, i_rdy, o_sop, o_eop, o_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: val/busy/rdy/sop/eop/err=%b, required 000000", {o_val, busy, i_rdy, o_sop, o_eop, o_err});
    end
    n_tests++;
    if (o_dat !== '0 || o_mod !== '0 || o_ctl !== '0) begin
      n_fail++;
      $display("FAIL reset_data: dat=%h mod=%0d ctl=%h, required zeros", o_dat, o_mod, o_ctl);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_full_packet();
    int w;
    o_rdy = 1'b1;
    send_beat({8{8'h11}}, 1'b1, 1'b0, 3'd0, 1'b0, 8'hA5, w);
    send_beat({8{8'h22}}, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, w);
    send_beat({8{8'h33}}, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, w);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_partial: o_busy=%b, required 1", busy);
    end
    send_beat({8{8'h44}}, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, w);
    n_tests++;
    if (o_val !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL latency: o_val=%b o_busy=%b, required 1 0", o_val, busy);
    end
    wait_drain();
  endtask

  task automatic test_mod_tail();
    int w;
    for (int i = 0; i < 6; i++)
      send_beat(64'h0101_0101_0101_0101 * (i + 1), i == 0, i == 5,
                (i == 5) ? 3'd3 : 3'd0, 1'b0, 8'(i + 8'h10), w);
    wait_drain();
  endtask

  task automatic test_single_beat();
    int w;
    send_beat(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b1, 3'd0, 1'b0, 8'h5A, w);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy: o_busy=%b, required 0", busy);
    end
    wait_drain();
  endtask

  task automatic test_hold();
    int    w;
    word_t snap, cur;
    o_rdy = 1'b0;
    for (int i = 0; i < 4; i++)
      send_beat({8{8'(8'hA0 + i)}}, i == 0, i == 3, 3'd0, 1'b0, 8'h77, w);
    drive_beat({8{8'hB0}}, 1'b1, 1'b0, 3'd0, 1'b0, 8'h88);
    @(negedge clk);
    snap = {o_dat, o_ctl, o_mod, o_sop, o_eop, o_err};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cur = {o_dat, o_ctl, o_mod, o_sop, o_eop, o_err};
      n_tests++;
      if (cur !== snap || o_val !== 1'b1 || i_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: cycle %0d val=%b rdy=%b dat=%h, required val=1 rdy=0 dat=%h", c, o_val, i_rdy, o_dat, snap.dat);
      end
    end
    @(posedge clk); #1;
    o_rdy = 1'b1;
    wait_accept(w);
    if (w <= 100) model_accept({8{8'hB0}}, 1'b1, 1'b0, 3'd0, 1'b0, 8'h88);
    for (int i = 1; i < 4; i++)
      send_beat({8{8'(8'hB0 + i)}}, 1'b0, i == 3, 3'd0, 1'b0, 8'h00, w);
    wait_drain();
  endtask

  task automatic test_err_fault();
    int w;
    for (int i = 0; i < 8; i++)
      send_beat({$urandom, $urandom}, i == 0 || i == 5, i == 7, 3'd0, i == 2, 8'(8'hC0 + i), w);
    wait_drain();
`ifdef AXI_UPSIZER_STATS_EN
    n_tests++;
    if (err_cnt !== 32'(exp_errs) || err_cnt !== 32'd2) begin
      n_fail++; $display("FAIL err_cnt: o_err_cnt=%0d, required %0d", err_cnt, exp_errs);
    end
    n_tests++;
    if (pkt_cnt !== 32'(exp_pkts)) begin
      n_fail++; $display("FAIL pkt_cnt: o_pkt_cnt=%0d, required %0d", pkt_cnt, exp_pkts);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int w, stalls;
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      send_beat({$urandom, $urandom}, (i % 4) == 0, (i % 4) == 3, 3'd0, 1'b0, 8'(i), w);
      stalls += w;
    end
    n_tests++;
    if (stalls != 0) begin
      n_fail++; $display("FAIL throughput: %0d stall cycles, required 0", stalls);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int w;
    send_beat({8{8'hEE}}, 1'b1, 1'b0, 3'd0, 1'b1, 8'h99, w);
    send_beat({8{8'hFF}}, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, w);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_val !== 1'b0 || busy !== 1'b0 || i_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: val=%b busy=%b rdy=%b, required 0 0 0", o_val, busy, i_rdy);
    end
    m_cnt = 0; exp_pkts = 0; exp_errs = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      send_beat({8{8'(8'h51 + i)}}, i == 0, i == 3, 3'd0, 1'b0, 8'h3C, w);
    wait_drain();
`ifdef AXI_UPSIZER_STATS_EN
    n_tests++;
    if (pkt_cnt !== 32'd1 || err_cnt !== 32'd0) begin
      n_fail++; $display("FAIL stats_after_reset: pkt=%0d err=%0d, required 1 0", pkt_cnt, err_cnt);
    end
`endif
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_full_packet();
    test_mod_tail();
    test_single_beat();
    test_hold();
    test_err_fault();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
